// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master with setup/hold framing around a DATA_WIDTH-bit MSB-first transfer.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_miso,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_ss_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rx_data
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d, ss_n_q, ss_n_d;
    logic                  busy_q, busy_d, done_q, done_d, half_end;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = 1'b0;
        half_end  = cnt_q == CW'(CLK_DIV - 1);
        if (state_q == SETUP || state_q == SHIFT || state_q == HOLD)
            cnt_d = half_end ? '0 : cnt_q + CW'(1);
        case (state_q)
            IDLE: if (i_start) begin
                state_d = SETUP;
                tx_d    = i_tx_data;
                rx_d    = '0;
                bit_d   = '0;
                cnt_d   = '0;
            end
            SETUP: state_d = half_end ? SHIFT : SETUP;
            SHIFT: begin
                sclk_d = half_end ? ~sclk_q : sclk_q;
                if (half_end && !sclk_q) rx_d = {rx_q[DATA_WIDTH-2:0], i_miso};
                // the last falling edge leaves the LSB on the line through HOLD
                if (half_end && sclk_q) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_WIDTH - 1)) state_d = HOLD;
                    else tx_d = tx_q << 1;
                end
            end
            HOLD: if (half_end) begin
                state_d   = DONE;
                rx_data_d = rx_q;
            end
            default: state_d = IDLE;
        endcase
        ss_n_d = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        mosi_d = ss_n_d ? 1'b0 : tx_d[DATA_WIDTH-1];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;
    assign o_ss_n    = ss_n_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rx_data = rx_data_q;
endmodule
